spi_slave_if: RTL
=================

Name: spi_slave_if

Overview:
- SPI mode-0 responder that terminates the frames issued by the team's SPI command master.
- Oversamples `sclk`/`cs`/`mosi` on the system clock and decodes the 12-bit command frame.
  - Write frames: presents a one-cycle write strobe to a local register bank.
  - Read frames: fetches one byte from the bank and shifts it out on `miso`, MSB first.

Parameters:
- CMD_WIDTH, 12: command frame length in bits; bit CMD_WIDTH-1 is R/W (1 = write, 0 = read).
- READ_WIDTH, 8: data field width and read-back width.
- ADDR_WIDTH, 3: address field width; CMD_WIDTH must equal 1+ADDR_WIDTH+READ_WIDTH.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers (minimum 2).

Ports:
- clk  in  1  system clock; sclk period must be at least 8 clk.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from master; idles low.
- cs  in  1  chip select, active low.
- mosi  in  1  master-to-slave data.
- miso  out  1  slave-to-master data.
- miso_oe  out  1  high while the slave drives miso.
- wr_vld  out  1  one-clk write strobe.
- wr_addr  out  ADDR_WIDTH  write address; valid with wr_vld.
- wr_data  out  READ_WIDTH  write data; valid with wr_vld.
- rd_req  out  1  one-clk read request.
- rd_addr  out  ADDR_WIDTH  read address; held from rd_req until frame end.
- rd_data  in  READ_WIDTH  read data; sampled exactly 2 clk after rd_req.
- frame_err  out  1  one-clk pulse on an aborted frame (see Optional Feature).

Behaviour:
- Reset values:
  - miso=0, miso_oe=0, wr_vld=0, rd_req=0, frame_err=0.
  - wr_addr, wr_data and rd_addr = 0.
  - State WAIT_IDLE; shift register and bit counter = 0.
- Input synchronization:
  - sclk, cs and mosi each pass through SYNC_STAGES flops.
  - Edge detect compares the last synchronized stage with one extra delay flop: rise = sclk_s & ~sclk_d, fall = ~sclk_s & sclk_d.
  - mosi is sampled from its synchronized stage in the cycle sclk rise is detected.
- States:
  - WAIT_IDLE: stay until cs_s = 1, then go to IDLE. This prevents joining a frame mid-way after reset.
  - IDLE: when cs_s falls to 0, clear bit counter and shift register, then go to CMD.
  - CMD: on each sclk rise, shift mosi into the LSB and increment the counter.
    - At the rise that makes count = CMD_WIDTH: if the R/W bit = 1, go to WR_COMMIT; else go to RD_FETCH.
  - WR_COMMIT:
    - Assert wr_vld for 1 clk; wr_addr = bits [CMD_WIDTH-2 -: ADDR_WIDTH], wr_data = bits [READ_WIDTH-1:0].
    - Then go to HOLD.
  - RD_FETCH:
    - Assert rd_req for 1 clk with rd_addr.
    - Capture rd_data 2 clk later into the tx shift register; the data bits of the command are ignored.
    - Go to RD_SHIFT.
  - RD_SHIFT:
    - miso_oe = 1. On each sclk fall, miso = tx[MSB] and tx shifts left.
    - The first fall after the command drives bit READ_WIDTH-1.
    - After READ_WIDTH bits have been driven, go to HOLD.
  - HOLD: ignore further sclk edges; when cs_s = 1, go to IDLE with miso_oe = 0 and miso = 0.
- Abort: cs_s = 1 in CMD, RD_FETCH or RD_SHIFT returns to IDLE. No wr_vld is issued; miso and miso_oe drop in the same cycle.
- Latency: wr_vld rises 1 clk after the 12th synchronized sclk rise, i.e. SYNC_STAGES+2 clk after the pin edge.
- Simultaneous events:
  - cs rise together with the final sclk rise: cs wins and the frame aborts.
  - A frame is never committed twice.
- Reset mid-frame: enter WAIT_IDLE; remaining edges of that frame are ignored.

Optional Feature:
- Macro: SPI_SLAVE_FRAME_ERR_EN.
- Defined: frame_err pulses 1 clk on every abort, i.e. cs high in CMD, RD_FETCH or RD_SHIFT.
- Also defined: frame_err pulses on any sclk rise in WAIT_IDLE while cs_s = 0.
- Undefined: frame_err is tied to 0 and no detection logic is built.

Decomposition:
- Package spi_pkg holds:
  - The state enum (WAIT_IDLE, IDLE, CMD, WR_COMMIT, RD_FETCH, RD_SHIFT, HOLD).
  - Localparams RW_BIT = CMD_WIDTH-1 and RD_LATENCY = 2.
  - Mode-0 constants CPOL=0 and CPHA=0, shared with the SPI master.
- One sub-module, spi_sync_edge: synchronizer chain plus rise/fall detect, instantiated for sclk.
  - cs and mosi use its synchronizer output only.

Test Plan:
- Write frame 12'hA5C (R/W=1, addr=3'b010, data=8'h5C) at sclk = clk/10 -> exactly one wr_vld; wr_addr=2, wr_data=8'h5C; rd_req stays 0.
- Read frame 12'h300 (R/W=0, addr=3'b011) plus 8 clocks; bench returns 8'hC3 two clk after rd_req -> rd_addr=3; miso bits sampled on sclk rises read 1,1,0,0,0,0,1,1; miso_oe high only inside the frame.
- cs deasserted after 7 bits of write frame 12'hFFF -> no wr_vld; FSM back in IDLE; next frame 12'h8AA gives wr_addr=0, wr_data=8'hAA; with SPI_SLAVE_FRAME_ERR_EN, one frame_err pulse.
- rst asserted after 5 bits, released while cs still low and sclk still toggling -> no wr_vld/rd_req for that frame; a new frame after cs high decodes correctly.
- Back-to-back write frames with 1 sclk period of cs high between -> two wr_vld pulses with the correct addr/data in order.
- Extra 4 sclk cycles after a 12-bit write -> still a single wr_vld; miso stays 0 and miso_oe stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 responder: FSM states, frame defaults
// and the mode constants common with the SPI command master.
package spi_pkg;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      CMD,
      WR_COMMIT,
      RD_FETCH,
      RD_SHIFT,
      HOLD
   } spi_state_e;

   localparam int unsigned CMD_WIDTH_DFLT   = 12;
   localparam int unsigned READ_WIDTH_DFLT  = 8;
   localparam int unsigned ADDR_WIDTH_DFLT  = 3;
   localparam int unsigned SYNC_STAGES_DFLT = 2;

   localparam int unsigned RW_BIT     = CMD_WIDTH_DFLT - 1;
   localparam int unsigned RD_LATENCY = 2;

   localparam bit CPOL = 1'b0;
   localparam bit CPHA = 1'b0;

   function automatic int unsigned rw_bit(input int unsigned cmd_width);
      return cmd_width - 1;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Pin synchronizer: STAGES-deep flop chains for the SPI clock and data pins,
// with rise/fall detection on the clock pin only.
module spi_sync_edge #(
   parameter int unsigned STAGES = 2,
   parameter int unsigned DATA_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              edge_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_s,
   output logic              rise,
   output logic              fall
);

   logic [STAGES-1:0] edge_chain;
   logic              edge_d;
   logic [DATA_W-1:0] data_chain [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         edge_chain <= '0;
         edge_d     <= 1'b0;
         // NOTE: the chain is reset on purpose so cs reads low until the pin has really been sampled.
         for (int i = 0; i < int'(STAGES); i++) data_chain[i] <= '0;
      end else begin
         edge_chain    <= {edge_chain[STAGES-2:0], edge_in};
         edge_d        <= edge_chain[STAGES-1];
         data_chain[0] <= data_in;
         for (int i = 1; i < int'(STAGES); i++) data_chain[i] <= data_chain[i-1];
      end
   end

   assign data_s = data_chain[STAGES-1];
   assign rise   = edge_chain[STAGES-1] & ~edge_d;
   assign fall   = ~edge_chain[STAGES-1] & edge_d;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 responder: decodes R/W + address + data command frames into write
// strobes or read fetches. Macro SPI_SLAVE_FRAME_ERR_EN enables frame_err pulses.
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int unsigned CMD_WIDTH   = CMD_WIDTH_DFLT,
   parameter int unsigned READ_WIDTH  = READ_WIDTH_DFLT,
   parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DFLT,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DFLT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  cs,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   output logic                  wr_vld,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [READ_WIDTH-1:0] wr_data,
   output logic                  rd_req,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [READ_WIDTH-1:0] rd_data,
   output logic                  frame_err
);

   localparam int unsigned RW_IDX   = rw_bit(CMD_WIDTH);
   localparam int unsigned ADDR_MSB = CMD_WIDTH - 2;
   localparam int unsigned CNT_W    = $clog2(CMD_WIDTH + 1);
   localparam int unsigned LAT_W    = $clog2(RD_LATENCY + 2);

   logic [1:0] pins_s;
   logic       cs_s, mosi_s, sclk_rise, sclk_fall;

   spi_sync_edge #(
      .STAGES (SYNC_STAGES),
      .DATA_W (2)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .edge_in (sclk),
      .data_in ({cs, mosi}),
      .data_s  (pins_s),
      .rise    (sclk_rise),
      .fall    (sclk_fall)
   );

   assign cs_s   = pins_s[1];
   assign mosi_s = pins_s[0];

   spi_state_e            state, state_nxt;
   logic [CNT_W-1:0]      bit_cnt, cnt_nxt;
   logic [CMD_WIDTH-2:0]  shreg, shreg_nxt;
   logic [CMD_WIDTH-1:0]  sh_full;
   logic [READ_WIDTH-1:0] tx, tx_nxt;
   logic [LAT_W-1:0]      lat_cnt, lat_nxt;
   logic                  fall_seen, fall_seen_nxt;
   logic                  miso_nxt, miso_oe_nxt, wr_vld_nxt, rd_req_nxt, abort;
   logic [ADDR_WIDTH-1:0] wr_addr_nxt, rd_addr_nxt;
   logic [READ_WIDTH-1:0] wr_data_nxt;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic                  stray;
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_nxt     = state;
      cnt_nxt       = bit_cnt;
      shreg_nxt     = shreg;
      sh_full       = {shreg, mosi_s};
      tx_nxt        = tx;
      lat_nxt       = lat_cnt;
      fall_seen_nxt = fall_seen;
      miso_nxt      = miso;
      miso_oe_nxt   = miso_oe;
      wr_vld_nxt    = 1'b0;
      wr_addr_nxt   = wr_addr;
      wr_data_nxt   = wr_data;
      rd_req_nxt    = 1'b0;
      rd_addr_nxt   = rd_addr;
      abort         = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      stray         = 1'b0;
`endif

      unique case (state)
         WAIT_IDLE: begin
            if (cs_s) state_nxt = IDLE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            else if (sclk_rise) stray = 1'b1;
`endif
         end
         IDLE: begin
            if (!cs_s) begin
               cnt_nxt   = '0;
               shreg_nxt = '0;
               state_nxt = CMD;
            end
         end
         CMD: begin
            if (cs_s) begin
               abort = 1'b1;
            end else if (sclk_rise) begin
               shreg_nxt = sh_full[CMD_WIDTH-2:0];
               cnt_nxt   = bit_cnt + CNT_W'(1);
               if (bit_cnt == CNT_W'(CMD_WIDTH - 1)) begin
                  lat_nxt       = '0;
                  fall_seen_nxt = 1'b0;
                  state_nxt     = sh_full[RW_IDX] ? WR_COMMIT : RD_FETCH;
               end
            end
         end
         WR_COMMIT: begin
            wr_vld_nxt  = 1'b1;
            wr_addr_nxt = shreg[ADDR_MSB -: ADDR_WIDTH];
            wr_data_nxt = shreg[READ_WIDTH-1:0];
            state_nxt   = HOLD;
         end
         RD_FETCH: begin
            if (cs_s) begin
               abort = 1'b1;
            end else begin
               lat_nxt = lat_cnt + LAT_W'(1);
               if (sclk_fall) fall_seen_nxt = 1'b1;
               if (lat_cnt == '0) begin
                  rd_req_nxt  = 1'b1;
                  rd_addr_nxt = shreg[ADDR_MSB -: ADDR_WIDTH];
               end
               // rd_req is registered, so the bank's data lands RD_LATENCY+1 cycles into this state.
               if (lat_cnt == LAT_W'(RD_LATENCY + 1)) begin
                  miso_oe_nxt = 1'b1;
                  state_nxt   = RD_SHIFT;
                  if (fall_seen || sclk_fall) begin
                     miso_nxt = rd_data[READ_WIDTH-1];
                     tx_nxt   = {rd_data[READ_WIDTH-2:0], 1'b0};
                     cnt_nxt  = CNT_W'(1);
                  end else begin
                     tx_nxt   = rd_data;
                     cnt_nxt  = '0;
                  end
               end
            end
         end
         RD_SHIFT: begin
            if (cs_s) begin
               abort = 1'b1;
            end else if (bit_cnt == CNT_W'(READ_WIDTH)) begin
               state_nxt = HOLD;
            end else if (sclk_fall) begin
               miso_nxt = tx[READ_WIDTH-1];
               tx_nxt   = {tx[READ_WIDTH-2:0], 1'b0};
               cnt_nxt  = bit_cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            if (cs_s) begin
               state_nxt   = IDLE;
               miso_nxt    = 1'b0;
               miso_oe_nxt = 1'b0;
            end
         end
         default: state_nxt = WAIT_IDLE;
      endcase

      if (abort) begin
         state_nxt   = IDLE;
         miso_nxt    = 1'b0;
         miso_oe_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= WAIT_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         tx        <= '0;
         lat_cnt   <= '0;
         fall_seen <= 1'b0;
         miso      <= 1'b0;
         miso_oe   <= 1'b0;
         wr_vld    <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         rd_req    <= 1'b0;
         rd_addr   <= '0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= cnt_nxt;
         shreg     <= shreg_nxt;
         tx        <= tx_nxt;
         lat_cnt   <= lat_nxt;
         fall_seen <= fall_seen_nxt;
         miso      <= miso_nxt;
         miso_oe   <= miso_oe_nxt;
         wr_vld    <= wr_vld_nxt;
         wr_addr   <= wr_addr_nxt;
         wr_data   <= wr_data_nxt;
         rd_req    <= rd_req_nxt;
         rd_addr   <= rd_addr_nxt;
      end
   end

`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic frame_err_q;

   always_ff @(posedge clk) begin
      if (rst) frame_err_q <= 1'b0;
      else     frame_err_q <= abort | stray;
   end

   assign frame_err = frame_err_q;
`else
   assign frame_err = 1'b0;
`endif

endmodule
